// File: rtl/popcount_pkg.sv
// Shared constants and types for the popcount pipeline.
// The frame accumulator honours the optional POPCOUNT_ACC_SAT_EN build macro.
package popcount_pkg;

    localparam int DATA_W = 10;
    localparam int POS_W  = 4;

    typedef enum logic {
        ACC_ACCUM,
        ACC_HOLD
    } acc_state_t;

endpackage

// File: rtl/popcount_acc_add.sv
// Frame-total adder: zero-extends the beat value and adds one carry bit of headroom.
// With POPCOUNT_ACC_SAT_EN the result clamps at all-ones and flags the clamp.
module popcount_acc_add
    import popcount_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [POS_W-1:0] add,
    output logic [ACC_W-1:0] sum,
    output logic             sat_hit
);

`ifdef POPCOUNT_ACC_SAT_EN
    localparam int WIDE_W = ACC_W + 1;

    logic [ACC_W:0] wide;

    assign wide    = {1'b0, acc} + WIDE_W'(add);
    assign sat_hit = wide[ACC_W];
    assign sum     = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
`else
    // The carry out is simply dropped, which is the mod 2^ACC_W wrap.
    assign sum     = acc + ACC_W'(add);
    assign sat_hit = 1'b0;
`endif

endmodule

// File: rtl/popcount_frame_acc.sv
// Frame accumulator behind the popcount stage: sums beats up to in_last or MAX_BEATS.
// Optional total saturation is enabled with the POPCOUNT_ACC_SAT_EN macro.
module popcount_frame_acc
    import popcount_pkg::*;
#(
    parameter int ACC_W     = 12,
    parameter int CNT_W     = 8,
    parameter int MAX_BEATS = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] in_sum,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [CNT_W-1:0] out_count,
    output logic             out_range_err,
    output logic             out_trunc,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [POS_W-1:0] SUM_MAX  = POS_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS);

    acc_state_t state_q;
    acc_state_t state_d;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             rerr_q;
    logic             sat_q;
    logic             sat_hit;
    logic             beat;
    logic             close;
    logic             beat_rerr;

    popcount_acc_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .acc    (acc_q),
        .add    (in_sum),
        .sum    (acc_sum),
        .sat_hit(sat_hit)
    );

    assign beat      = in_valid && in_ready;
    assign cnt_inc   = cnt_q + 1'b1;
    assign close     = beat && (in_last || cnt_inc == CNT_LAST);
    assign beat_rerr = in_sum > SUM_MAX;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ACC_ACCUM: begin
                in_ready = 1'b1;
                if (close) begin
                    state_d = ACC_HOLD;
                end
            end
            ACC_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ACC_ACCUM;
                end
            end
            default: state_d = ACC_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ACC_ACCUM;
            acc_q         <= '0;
            cnt_q         <= '0;
            rerr_q        <= 1'b0;
            sat_q         <= 1'b0;
            out_total     <= '0;
            out_count     <= '0;
            out_range_err <= 1'b0;
            out_trunc     <= 1'b0;
            out_sat       <= 1'b0;
        end else begin
            state_q <= state_d;
            // Output registers load only on close, so they hold through HOLD.
            if (close) begin
                out_total     <= acc_sum;
                out_count     <= cnt_inc;
                out_range_err <= rerr_q | beat_rerr;
                out_trunc     <= !in_last;
                out_sat       <= sat_q | sat_hit;
                acc_q         <= '0;
                cnt_q         <= '0;
                rerr_q        <= 1'b0;
                sat_q         <= 1'b0;
            end else if (beat) begin
                acc_q  <= acc_sum;
                cnt_q  <= cnt_inc;
                rerr_q <= rerr_q | beat_rerr;
                sat_q  <= sat_q | sat_hit;
            end
        end
    end

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Scoreboard bench for popcount_frame_acc: default instance plus a small
// ACC_W=5 / MAX_BEATS=4 instance; expectations follow POPCOUNT_ACC_SAT_EN.
module tb_popcount_frame_acc;

    typedef struct {
        int total;
        int count;
        int rerr;
        int trunc;
        int sat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0][3:0] in_sum;
    logic [1:0]      in_valid;
    logic [1:0]      in_last;
    logic [1:0]      out_ready;
    wire  [1:0]      in_ready;
    wire  [1:0]      out_valid;
    wire  [1:0]      out_range_err;
    wire  [1:0]      out_trunc;
    wire  [1:0]      out_sat;
    wire  [11:0]     tot0;
    wire  [4:0]      tot1;
    wire  [7:0]      cnt0;
    wire  [7:0]      cnt1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    popcount_frame_acc u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .in_sum       (in_sum[0]),
        .in_valid     (in_valid[0]),
        .in_last      (in_last[0]),
        .in_ready     (in_ready[0]),
        .out_total    (tot0),
        .out_count    (cnt0),
        .out_range_err(out_range_err[0]),
        .out_trunc    (out_trunc[0]),
        .out_sat      (out_sat[0]),
        .out_valid    (out_valid[0]),
        .out_ready    (out_ready[0])
    );

    popcount_frame_acc #(
        .ACC_W    (5),
        .CNT_W    (8),
        .MAX_BEATS(4)
    ) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .in_sum       (in_sum[1]),
        .in_valid     (in_valid[1]),
        .in_last      (in_last[1]),
        .in_ready     (in_ready[1]),
        .out_total    (tot1),
        .out_count    (cnt1),
        .out_range_err(out_range_err[1]),
        .out_trunc    (out_trunc[1]),
        .out_sat      (out_sat[1]),
        .out_valid    (out_valid[1]),
        .out_ready    (out_ready[1])
    );

    function automatic int total_of(input int i);
        return (i == 0) ? int'(tot0) : int'(tot1);
    endfunction

    function automatic int count_of(input int i);
        return (i == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic push(input int i, input int t, input int c,
                        input int re, input int tr, input int sa);
        exp_t e;
        e.total = t;
        e.count = c;
        e.rerr  = re;
        e.trunc = tr;
        e.sat   = sa;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic beat(input int i, input int s, input bit l);
        int t;
        t = 0;
        @(negedge clk);
        in_sum[i]   = 4'(s);
        in_last[i]  = l;
        in_valid[i] = 1'b1;
        while (!in_ready[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout inst%0d got=in_ready0 exp=in_ready1", i);
        end
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   gt;
        int   gc;
        for (int i = 0; i < 2; i++) begin
            if (!rst && out_valid[i] && out_ready[i]) begin
                checks++;
                gt = total_of(i);
                gc = count_of(i);
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    errors++;
                    $display("FAIL unexpected_result inst%0d got total=%0d count=%0d exp none",
                             i, gt, gc);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    if (gt != e.total || gc != e.count ||
                        int'(out_range_err[i]) != e.rerr ||
                        int'(out_trunc[i]) != e.trunc ||
                        int'(out_sat[i]) != e.sat) begin
                        errors++;
                        $display("FAIL result inst%0d got t=%0d c=%0d re=%0d tr=%0d sa=%0d exp t=%0d c=%0d re=%0d tr=%0d sa=%0d",
                                 i, gt, gc, out_range_err[i], out_trunc[i], out_sat[i],
                                 e.total, e.count, e.rerr, e.trunc, e.sat);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        in_sum    = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 2'b11;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready0", int'(in_ready[0]), 1);
        chk("rst_out_valid0", int'(out_valid[0]), 0);
        chk("rst_total0", total_of(0), 0);
        chk("rst_count0", count_of(0), 0);
        chk("rst_flags0", int'({out_range_err[0], out_trunc[0], out_sat[0]}), 0);
        chk("rst_in_ready1", int'(in_ready[1]), 1);
        chk("rst_out_valid1", int'(out_valid[1]), 0);
        rst = 1'b0;

        // basic frame, latency and one-cycle hold
        push(0, 20, 4, 0, 0, 0);
        beat(0, 3, 0);
        beat(0, 10, 0);
        beat(0, 0, 0);
        beat(0, 7, 1);
        chk("lat_out_valid", int'(out_valid[0]), 1);
        chk("hold_in_ready", int'(in_ready[0]), 0);
        @(posedge clk);
        #1;
        chk("valid_fall", int'(out_valid[0]), 0);
        chk("accum_in_ready", int'(in_ready[0]), 1);

        // backpressure
        out_ready[0] = 1'b0;
        push(0, 20, 4, 0, 0, 0);
        beat(0, 3, 0);
        beat(0, 10, 0);
        beat(0, 0, 0);
        beat(0, 7, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready[0]), 0);
            chk("bp_out_valid", int'(out_valid[0]), 1);
            chk("bp_total", total_of(0), 20);
            chk("bp_count", count_of(0), 4);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;

        // range error then a clean single-beat frame
        push(0, 13, 2, 1, 0, 0);
        beat(0, 11, 0);
        beat(0, 2, 1);
        push(0, 1, 1, 0, 0, 0);
        beat(0, 1, 1);
        push(0, 15, 1, 1, 0, 0);
        beat(0, 15, 1);

        // mid-frame reset
        beat(0, 5, 0);
        beat(0, 6, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push(0, 4, 1, 0, 0, 0);
        beat(0, 4, 1);

        // pending result discarded by reset
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        beat(0, 9, 1);
        chk("pend_out_valid", int'(out_valid[0]), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("pend_drop_valid", int'(out_valid[0]), 0);
        chk("pend_drop_total", total_of(0), 0);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;

        // truncation at MAX_BEATS=4
        push(1, 20, 4, 0, 1, 0);
        push(1, 10, 2, 0, 0, 0);
        repeat (5) beat(1, 5, 0);
        beat(1, 5, 1);

        // overflow on a 5-bit total
`ifdef POPCOUNT_ACC_SAT_EN
        push(1, 31, 4, 0, 0, 1);
`else
        push(1, 8, 4, 0, 0, 0);
`endif
        repeat (3) beat(1, 10, 0);
        beat(1, 10, 1);

        repeat (4) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
